// File: rtl/palindrome_tx.sv
// Serial palindrome transmitter: sends a WIDTH-bit word MSB first, then its mirror image.
// Build option PAL_ODD_EN: odd-length frames (centre bit d0 sent once, 2*WIDTH-1 bits).
module palindrome_tx #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             x_o,
    output logic             x_valid_o,
    output logic             last_o
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifdef PAL_ODD_EN
    localparam logic [CW-1:0] REV_START = CW'(1);
`else
    localparam logic [CW-1:0] REV_START = CW'(0);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        REV  = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] d, d_n;
    logic             x_n, x_valid_n, last_n;

    assign ready_o = (state == IDLE) & reset;

    // Next state, then outputs derived from the next state so they line up with it.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        d_n       = d;
        x_n       = 1'b0;
        x_valid_n = 1'b0;
        last_n    = 1'b0;

        case (state)
            IDLE: begin
                if (valid_i && ready_o) begin
                    state_n = FWD;
                    cnt_n   = '0;
                    d_n     = data_i;
                end
            end
            FWD: begin
                if (cnt == LAST) begin
                    state_n = REV;
                    cnt_n   = REV_START;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            REV: begin
                if (cnt == LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        case (state_n)
            FWD: begin
                x_valid_n = 1'b1;
                x_n       = d_n[LAST - cnt_n];
            end
            REV: begin
                x_valid_n = 1'b1;
                x_n       = d_n[cnt_n];
                last_n    = (cnt_n == LAST);
            end
            default: begin
                x_valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            d         <= '0;
            x_o       <= 1'b0;
            x_valid_o <= 1'b0;
            last_o    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            d         <= d_n;
            x_o       <= x_n;
            x_valid_o <= x_valid_n;
            last_o    <= last_n;
        end
    end

endmodule
